// File: rtl/pp_pipeline_accel_stage_sequencer.sv
// Runs NUM_STAGES ap_ctrl_chain children in index order, latches each child's ap_return,
// and exposes one ap_ctrl_chain handshake upward. A per-stage watchdog aborts a hung child.
module pp_pipeline_accel_stage_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int RET_W      = 32,
  parameter int TIMEOUT_W  = 16,
  localparam int ST_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  output logic                        ap_done,
  input  logic                        ap_continue,
  output logic                        ap_idle,
  output logic                        ap_ready,
  output logic [NUM_STAGES-1:0]       child_start,
  input  logic [NUM_STAGES-1:0]       child_ready,
  input  logic [NUM_STAGES-1:0]       child_done,
  output logic [NUM_STAGES-1:0]       child_continue,
  input  logic [NUM_STAGES*RET_W-1:0] child_return,
  output logic [NUM_STAGES*RET_W-1:0] stage_return,
  input  logic [TIMEOUT_W-1:0]        timeout_limit,
  output logic                        err_timeout,
  output logic [ST_W-1:0]             err_stage
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  localparam logic [ST_W-1:0] LAST = ST_W'(NUM_STAGES - 1);

  state_t               state, state_n;
  logic [ST_W-1:0]      stage;
  logic [TIMEOUT_W-1:0] wdog;
  logic                 ready_q;
  logic                 sel_ready, sel_done;
  logic                 complete, timeout_hit, wdog_hit;

  assign wdog_hit = (timeout_limit != '0) && (wdog == timeout_limit);

  always_comb begin
    sel_ready = 1'b0;
    sel_done  = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (stage == ST_W'(k)) begin
        sel_ready = child_ready[k];
        sel_done  = child_done[k];
      end
    end
  end

  // Completion is checked before the watchdog so a child finishing on the limit cycle still counts.
  always_comb begin
    state_n        = state;
    complete       = 1'b0;
    timeout_hit    = 1'b0;
    child_start    = '0;
    child_continue = '0;
    unique case (state)
      IDLE: if (ap_start) state_n = LAUNCH;
      LAUNCH, WAIT: begin
        if (sel_done)                          complete    = 1'b1;
        else if (wdog_hit)                     timeout_hit = 1'b1;
        else if (state == LAUNCH && sel_ready) state_n     = WAIT;
        if (complete)    state_n = (stage == LAST) ? DONE : LAUNCH;
        if (timeout_hit) state_n = DONE;
      end
      DONE: if (ap_continue) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      child_start[k]    = (state == LAUNCH) && (stage == ST_W'(k));
      child_continue[k] = complete && (stage == ST_W'(k));
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= IDLE;
      stage        <= '0;
      wdog         <= '0;
      ready_q      <= 1'b0;
      stage_return <= '0;
      err_timeout  <= 1'b0;
      err_stage    <= '0;
    end else begin
      state   <= state_n;
      ready_q <= (state != DONE) && (state_n == DONE);
      if (state == IDLE && ap_start) begin
        stage       <= '0;
        wdog        <= '0;
        err_timeout <= 1'b0;
      end else if (state == LAUNCH || state == WAIT) begin
        if (complete) begin
          for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (stage == ST_W'(k))
              stage_return[k*RET_W +: RET_W] <= child_return[k*RET_W +: RET_W];
          end
          if (stage != LAST) begin
            stage <= stage + 1'b1;
            wdog  <= '0;
          end
        end else begin
          wdog <= wdog + 1'b1;
          if (timeout_hit) begin
            err_timeout <= 1'b1;
            err_stage   <= stage;
          end
        end
      end
    end
  end

  assign ap_done  = (state == DONE);
  assign ap_ready = ready_q;
  assign ap_idle  = (state == IDLE) && !ap_start;

endmodule

// File: tb/tb_pp_pipeline_accel_stage_sequencer.sv
// Scoreboard bench: behavioural children and a per-sequence timing/return model feed a queue
// that a negedge monitor drains whenever the sequencer raises ap_done.
module tb_pp_pipeline_accel_stage_sequencer;
  localparam int N  = 3;
  localparam int RW = 32;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ap_start = 1'b0, ap_continue = 1'b0;
  logic            ap_done, ap_idle, ap_ready;
  logic [N-1:0]    child_start, child_ready, child_done, child_continue;
  logic [N*RW-1:0] child_return, stage_return;
  logic [TW-1:0]   timeout_limit = '0;
  logic            err_timeout;
  logic [1:0]      err_stage;

  pp_pipeline_accel_stage_sequencer #(.NUM_STAGES(N), .RET_W(RW), .TIMEOUT_W(TW)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .child_start(child_start), .child_ready(child_ready), .child_done(child_done),
    .child_continue(child_continue), .child_return(child_return), .stage_return(stage_return),
    .timeout_limit(timeout_limit), .err_timeout(err_timeout), .err_stage(err_stage)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural children: ready on cycle cfg_r (0 = never), done from cycle cfg_d on (0 = hang).
  int          cnt   [N];
  int          cfg_r [N];
  int          cfg_d [N];
  logic [RW-1:0] cfg_ret [N];
  logic        child_clr = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (child_clr || child_continue[k]) cnt[k] <= 0;
      else if (child_start[k] || cnt[k] != 0) cnt[k] <= cnt[k] + 1;
    end
  end

  always_comb begin
    child_ready  = '0;
    child_done   = '0;
    child_return = '0;
    for (int k = 0; k < N; k++) begin
      child_ready[k] = (child_start[k] || cnt[k] != 0) && cfg_r[k] != 0 && (cnt[k] + 1 == cfg_r[k]);
      child_done[k]  = (child_start[k] || cnt[k] != 0) && cfg_d[k] != 0 && (cnt[k] + 1 >= cfg_d[k]);
      child_return[k*RW +: RW] = cfg_ret[k];
    end
  end

  typedef struct packed {
    logic [31:0]          done_at;
    logic [N*RW-1:0]      ret;
    logic                 err;
    logic [1:0]           est;
    logic [N-1:0][15:0]   st_cyc;
    logic [N-1:0]         cont;
  } exp_t;

  exp_t            q[$];
  logic [N*RW-1:0] ret_model = '0;

  // Each stage lasts until its child's done cycle, or limit+1 cycles when the watchdog trips first.
  function automatic exp_t model(input int unsigned p, input int unsigned lim);
    exp_t e;
    int unsigned t = 0;
    bit aborted = 0;
    e = '0;
    e.ret = ret_model;
    for (int k = 0; k < N; k++) begin
      if (!aborted) begin
        int unsigned d, rp, s;
        d  = (cfg_d[k] == 0) ? 32'hFFFF_FFFF : cfg_d[k];
        rp = (cfg_r[k] == 0 || cfg_r[k] > d) ? d : cfg_r[k];
        if (lim != 0 && d > lim + 1) begin
          s = lim + 1; aborted = 1; e.err = 1'b1; e.est = 2'(k);
        end else begin
          s = d; e.cont[k] = 1'b1; e.ret[k*RW +: RW] = cfg_ret[k];
        end
        e.st_cyc[k] = 16'((rp < s) ? rp : s);
        t += s;
      end
    end
    e.done_at = p + t;
    return e;
  endfunction

  int   sc [N];
  int   cc [N];
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin sc[k] = 0; cc[k] = 0; end
      prev_done = 1'b0;
    end else begin
      chk("one_hot", 128'(($countones(child_start) > 1) || ($countones(child_continue) > 1)), 128'(0));
      chk("ap_ready_pulse", 128'(ap_ready), 128'(ap_done && !prev_done));
      if (child_continue != '0) chk("continue_with_done", 128'(child_continue & ~child_done), 128'(0));
      for (int k = 0; k < N; k++) begin
        sc[k] += int'(child_start[k]);
        cc[k] += int'(child_continue[k]);
      end
      if (ap_done && !prev_done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 128'(1), 128'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", 128'(cyc), 128'(e.done_at));
          chk("stage_return", 128'(stage_return), 128'(e.ret));
          chk("err_timeout", 128'(err_timeout), 128'(e.err));
          if (e.err) chk("err_stage", 128'(err_stage), 128'(e.est));
          for (int k = 0; k < N; k++) begin
            chk("start_cycles", 128'(sc[k]), 128'(e.st_cyc[k]));
            chk("continue_pulses", 128'(cc[k]), 128'(e.cont[k]));
            sc[k] = 0; cc[k] = 0;
          end
        end
      end
      prev_done = ap_done;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0; child_clr = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; child_clr = 1'b0;
    ret_model = '0;
    q.delete();
  endtask

  task automatic run_seq(input int unsigned lim, input int hold, input bit pulse_start);
    exp_t e;
    int n;
    @(negedge clk); child_clr = 1'b1;
    @(negedge clk); child_clr = 1'b0;
    timeout_limit = TW'(lim);
    chk("idle_before_start", 128'(ap_idle), 128'(1));
    e = model(cyc + 1, lim);
    q.push_back(e);
    ret_model = e.ret;
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    chk("err_cleared_on_start", 128'(err_timeout), 128'(0));
    n = 0;
    while (!ap_done && n < 3000) begin
      ap_continue = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    ap_continue = 1'b0;
    if (!ap_done) begin
      chk("done_timeout", 128'(0), 128'(1));
      do_reset();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      ap_start = pulse_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      chk("done_held", 128'(ap_done), 128'(1));
      chk("no_start_in_done", 128'(child_start), 128'(0));
    end
    ap_start = 1'b0;
    ap_continue = 1'b1;
    @(negedge clk);
    ap_continue = 1'b0;
    chk("idle_after_continue", 128'(ap_idle), 128'(1));
    chk("done_cleared", 128'(ap_done), 128'(0));
  endtask

  task automatic set_child(input int k, input int r, input int d, input logic [RW-1:0] ret);
    cfg_r[k] = r; cfg_d[k] = d; cfg_ret[k] = ret;
  endtask

  initial begin
    for (int k = 0; k < N; k++) set_child(k, 2, 2, '0);
    do_reset();
    chk("rst_done", 128'(ap_done), 128'(0));
    chk("rst_ready", 128'(ap_ready), 128'(0));
    chk("rst_start", 128'(child_start), 128'(0));
    chk("rst_stage_return", 128'(stage_return), 128'(0));
    chk("rst_err", 128'({err_timeout, err_stage}), 128'(0));
    chk("rst_idle", 128'(ap_idle), 128'(1));

    // 2-cycle children returning 0x10/0x20/0x30
    set_child(0, 2, 2, 32'h10); set_child(1, 2, 2, 32'h20); set_child(2, 2, 2, 32'h30);
    run_seq(0, 0, 0);
    chk("basic_return", 128'(stage_return), 128'({32'h30, 32'h20, 32'h10}));
    // Child 1 ready early, done late: WAIT path
    set_child(1, 1, 5, 32'h21);
    run_seq(0, 0, 0);
    // Consumer stalls with ap_start pulsing during DONE
    run_seq(0, 10, 1);
    // Watchdog on a hung last child, then a clean sequence clears the error
    set_child(1, 2, 2, 32'h22); set_child(2, 1, 0, 32'hDEAD);
    run_seq(5, 2, 0);
    chk("timeout_stage2_start_low", 128'(child_start), 128'(0));
    set_child(2, 3, 3, 32'h33);
    run_seq(5, 0, 0);
    // Completion exactly on the watchdog limit cycle
    set_child(0, 0, 6, 32'h44);
    run_seq(5, 0, 0);
    // Watchdog disabled, very slow child
    set_child(0, 1, 1000, 32'h55);
    run_seq(0, 0, 0);

    for (int s = 0; s < 40; s++) begin
      int unsigned lim;
      lim = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 7);
      for (int k = 0; k < N; k++) begin
        int d;
        d = $urandom_range(1, 9);
        if (lim != 0 && $urandom_range(0, 7) == 0) d = 0;
        set_child(k, $urandom_range(0, (d == 0) ? 4 : d), d, $urandom);
      end
      run_seq(lim, $urandom_range(0, 4), 1);
    end

    // Asynchronous reset in the middle of WAIT
    set_child(0, 1, 50, 32'h66);
    @(negedge clk); child_clr = 1'b1;
    @(negedge clk); child_clr = 1'b0; timeout_limit = '0; ap_start = 1'b1;
    @(negedge clk); ap_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 128'({ap_done, ap_ready, child_start, child_continue, err_timeout, err_stage}), 128'(0));
    chk("async_rst_stage_return", 128'(stage_return), 128'(0));
    q.delete();
    @(negedge clk);
    do_reset();
    chk("idle_after_reset", 128'(ap_idle), 128'(1));
    set_child(0, 2, 2, 32'h77);
    run_seq(0, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 128'(q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
